// File: rtl/interval_meter_pkg.sv
// interval_meter_pkg: shared types for the interval meter
package interval_meter_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, COUNTING} meter_state_t;
endpackage

// File: rtl/interval_meter_sat_counter.sv
// sat_counter: loadable saturating up-counter with sticky saturation flag
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             saturated
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      value     <= '0;
      saturated <= 1'b0;
    end else if (load) begin
      value     <= WIDTH'(1);
      saturated <= 1'b0;
    end else if (en) begin
      if (&value) saturated <= 1'b1;
      else        value     <= value + WIDTH'(1);
    end
endmodule

// File: rtl/interval_meter.sv
// interval_meter: counts clock edges from start to stop after being armed by go
module interval_meter
  import interval_meter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             done
);
  meter_state_t state, nxt;
  logic load, en, cap;
  logic [WIDTH-1:0] value;
  logic saturated;
  sat_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk),
    .rst(rst),
    .load(load),
    .en(en),
    .value(value),
    .saturated(saturated)
  );
  always_comb begin
    load = (state == ARMED) && start && !go;
    cap  = (state == COUNTING) && stop && !go;
    en   = (state == COUNTING) && !stop && !go;
    nxt  = go ? ARMED : load ? COUNTING : cap ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b1;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= nxt;
      done  <= (nxt == IDLE);
      if (go) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (cap) begin
        count    <= value;
        overflow <= saturated;
      end
    end
endmodule

// File: tb/tb_interval_meter.sv
// tb_interval_meter: directed checks of interval_meter at WIDTH=32 and WIDTH=4
module tb_interval_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go = 1'b0, start = 1'b0, stop = 1'b0;
  logic [31:0] count;
  logic overflow, done;
  logic [3:0] count_s;
  logic overflow_s, done_s;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  interval_meter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .go(go), .start(start), .stop(stop),
    .count(count), .overflow(overflow), .done(done)
  );
  interval_meter #(.WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .go(go), .start(start), .stop(stop),
    .count(count_s), .overflow(overflow_s), .done(done_s)
  );
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task tick(input logic g, input logic s, input logic p);
    go = g;
    start = s;
    stop = p;
    @(posedge clk);
    #1;
    go = 1'b0;
    start = 1'b0;
    stop = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_done", 32'(done), 1);
    chk("rst_count", count, 0);
    chk("rst_ovf", 32'(overflow), 0);
    tick(0, 1, 0);
    tick(0, 0, 1);
    repeat (3) tick(0, 0, 0);
    chk("idle_done", 32'(done), 1);
    chk("idle_count", count, 0);
    tick(1, 0, 0);
    chk("go_done", 32'(done), 0);
    chk("go_count", count, 0);
    repeat (2) tick(0, 0, 0);
    tick(0, 1, 0);
    repeat (4) tick(0, 0, 0);
    chk("cnt5_busy", 32'(done), 0);
    tick(0, 0, 1);
    chk("cnt5_done", 32'(done), 1);
    chk("cnt5_count", count, 5);
    chk("cnt5_ovf", 32'(overflow), 0);
    chk("cnt5_count_s", 32'(count_s), 5);
    tick(0, 0, 0);
    chk("cnt5_hold", count, 5);
    tick(1, 0, 0);
    tick(0, 1, 1);
    chk("same_busy", 32'(done), 0);
    tick(0, 0, 1);
    chk("min_done", 32'(done), 1);
    chk("min_count", count, 1);
    tick(1, 0, 0);
    tick(0, 1, 0);
    for (int i = 7; i > 1; i--) tick(0, 0, 0);
    tick(0, 0, 1);
    chk("timer7_count", count, 7);
    tick(1, 0, 0);
    tick(0, 1, 0);
    repeat (19) tick(0, 0, 0);
    tick(0, 0, 1);
    chk("sat_count_wide", count, 20);
    chk("sat_ovf_wide", 32'(overflow), 0);
    chk("sat_done_s", 32'(done_s), 1);
    chk("sat_count_s", 32'(count_s), 15);
    chk("sat_ovf_s", 32'(overflow_s), 1);
    tick(1, 0, 0);
    chk("regon_count_s", 32'(count_s), 0);
    chk("regon_ovf_s", 32'(overflow_s), 0);
    chk("regon_done_s", 32'(done_s), 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(1, 0, 1);
    chk("gostop_done", 32'(done), 0);
    chk("gostop_count", count, 0);
    tick(0, 1, 0);
    repeat (2) tick(0, 0, 0);
    chk("cnt3_busy", 32'(done), 0);
    tick(0, 0, 1);
    chk("cnt3_count", count, 3);
    tick(1, 0, 0);
    tick(0, 1, 0);
    repeat (3) tick(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_done", 32'(done), 1);
    chk("arst_count", count, 0);
    #1 rst = 1'b0;
    tick(0, 0, 1);
    chk("post_rst_done", 32'(done), 1);
    chk("post_rst_count", count, 0);
    tick(0, 1, 0);
    chk("post_rst_start", 32'(done), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/interval_meter.md
# interval_meter

Measures elapsed clock cycles between a start event and a stop event: the inverse of the timer block, which turns a cycle count into a delay. The host arms the meter with `go`. The meter counts from the first `start` pulse to the next `stop` pulse, then holds the result with `done` asserted until re-armed. It sits beside the timer in timing/latency characterization paths. Its primary self-check drives a timer's `go` and `done` into this block's `start` and `stop`.

## Interface
- `WIDTH`, default 32: width of the count output and the internal counter.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `go`  in  1  arm or re-arm the meter. Clears the previous result.
- `start`  in  1  start event; sampled only in ARMED.
- `stop`  in  1  stop event; sampled only in COUNTING.
- `count`  out  WIDTH  measured cycles. Valid while `done`=1.
- `overflow`  out  1  the measurement saturated at 2^WIDTH-1. Valid while `done`=1.
- `done`  out  1  high when no measurement is in progress. Held until the next `go`.

## Operation
- States:
  - IDLE: `done`=1.
  - ARMED: `done`=0, waiting for `start`.
  - COUNTING: `done`=0, waiting for `stop`.
- IDLE, `go`=1 -> ARMED. `count`<=0, `overflow`<=0.
- ARMED, `go`=1 -> stays ARMED, re-armed. `start`, `stop` ignored that cycle.
- ARMED, `start`=1, `go`=0 -> COUNTING, internal `cnt_r`<=1. `stop` is ignored in ARMED, including in the same cycle as `start`.
- COUNTING, `go`=1 -> ARMED. `count`<=0, `overflow`<=0, `cnt_r` discarded. `go` beats a simultaneous `stop`.
- COUNTING, `stop`=1, `go`=0 -> IDLE. `count`<=`cnt_r`, `overflow`<=`sat_r`.
- COUNTING, otherwise:
  - if `cnt_r` = 2^WIDTH-1: `cnt_r` holds and `sat_r`<=1.
  - else `cnt_r`<=`cnt_r`+1.
  - `cnt_r` never wraps.
- `start` in IDLE or COUNTING: ignored. `stop` in IDLE or ARMED: ignored.
- Result semantics: `stop` sampled k clock edges after the edge that sampled `start` gives `count`=k.
  - The minimum result is 1.
  - If a timer's `go` with `cycles`=N drives `start`, and that timer's `done` rising edge drives `stop`, then `count`=N.
- All outputs come directly from registers. No combinational path from inputs to outputs.

## Timing
- Reset values: state IDLE, `done`=1, `count`=0, `overflow`=0, `cnt_r`=0, `sat_r`=0.
- Reset asserted mid-measurement aborts immediately (asynchronously). No partial result is retained.
- `go` sampled at edge t: `done`=0 and `count`=0 from t+1.
- `stop` accepted at edge t: `done`=1 and `count` valid from t+1.
- A back-to-back `go` in the cycle `done` rises is legal. It re-arms and clears the result at the next edge.
- Throughput: one measurement per k+2 cycles minimum (go, start, then k counting edges).

## Structure
- Package `interval_meter_pkg`:
  - state enum `meter_state_t` {IDLE, ARMED, COUNTING}.
- One sub-module, `sat_counter` (parameter WIDTH), owns `cnt_r` and `sat_r`. Ports:
  - `clk`, `rst`.
  - `load` (load value 1, clear `sat_r`).
  - `en` (saturating increment).
  - `value`, `saturated`.
- The top level holds the FSM and the result registers.

## Test plan
- Reset release with no stimulus -> `done`=1, `count`=0, `overflow`=0 held indefinitely; `start`/`stop` pulses change nothing.
- `go`@t0, `start`@t0+3, `stop`@t0+8 -> `done` falls at t0+1 and rises at t0+9; `count`=5, `overflow`=0.
- `start` and `stop` in the same cycle while ARMED, then `stop` 1 cycle later -> `count`=1. A timer with `cycles`=7 wired in (timer `go` -> `start`, timer `done` rising edge -> `stop`) -> `count`=7.
- WIDTH=4, `stop` 20 cycles after `start` -> `count`=15, `overflow`=1. A following `go` clears both to 0.
- `go` asserted in COUNTING together with `stop` -> the meter returns to ARMED, `done` stays 0, `count`=0. A later `start`, then `stop` after 3 cycles -> `count`=3.
- `rst` pulsed mid-COUNTING (async, between edges) -> `done`=1 and `count`=0 immediately. `stop` after reset is ignored.
